// File: rtl/buzzer_arbiter_if.sv
// Request/beep bundle between the game cores and the buzzer arbiter.
// The master side drives requests; the slave side drives buzzer status.
interface buzzer_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   REQ;
    logic [3*N_REQ-1:0] REP;
    logic               BUZZER;
    logic               BUSY;
    logic [N_REQ-1:0]   GRANT;
    logic [N_REQ-1:0]   DONE;

    modport master (
        output REQ, REP,
        input  BUZZER, BUSY, GRANT, DONE
    );

    modport slave (
        input  REQ, REP,
        output BUZZER, BUSY, GRANT, DONE
    );
endinterface

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, non-preemptive sharing of the board buzzer.
// Each grant plays REP on/off bursts timed by a tick prescaler.
module buzzer_arbiter #(
    parameter int          N_REQ     = 3,
    parameter int unsigned TICK_DIV  = 2000000,
    parameter int          ON_TICKS  = 4,
    parameter int          OFF_TICKS = 2
) (
    input logic             CK,
    input logic             RB,
    buzzer_arbiter_if.slave bus
);

    localparam int CW     = $clog2(TICK_DIV + 1);
    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW     = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ON_LAST  = PW'(ON_TICKS - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } state_t;

    state_t           state_q, state_n;
    logic [N_REQ-1:0] pend_q, pend_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [N_REQ-1:0] done_q, done_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [PW-1:0]    phase_q, phase_n;
    logic [2:0]       rep_q, rep_n;
    logic             buzzer_q;
    logic [N_REQ-1:0] pick;
    logic [2:0]       rep_sel;
    logic             tick;

    // Lowest set bit of pend is the highest-priority waiter
    assign pick = pend_q & (~pend_q + N_REQ'(1));
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        rep_sel = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) rep_sel = bus.REP[3*i +: 3];
        end
        if (rep_sel == 3'd0) rep_sel = 3'd1;
    end

    always_comb begin
        state_n = state_q;
        pend_n  = pend_q | bus.REQ;
        grant_n = grant_q;
        done_n  = '0;
        cnt_n   = cnt_q;
        phase_n = phase_q;
        rep_n   = rep_q;
        if (state_q != IDLE) begin
            cnt_n = tick ? '0 : cnt_q + CW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_n = ON;
                    grant_n = pick;
                    pend_n  = (pend_q | bus.REQ) & ~pick;
                    rep_n   = rep_sel;
                    phase_n = '0;
                    cnt_n   = '0;
                end
            end
            ON: begin
                if (tick) begin
                    if (phase_q == ON_LAST) begin
                        phase_n = '0;
                        rep_n   = rep_q - 3'd1;
                        state_n = (rep_q == 3'd1) ? GAP : OFF;
                    end else begin
                        phase_n = phase_q + PW'(1);
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_n = '0;
                        state_n = ON;
                    end else begin
                        phase_n = phase_q + PW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_n = '0;
                        state_n = IDLE;
                        done_n  = grant_q;
                        grant_n = '0;
                    end else begin
                        phase_n = phase_q + PW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            rep_q    <= 3'd0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            pend_q   <= pend_n;
            grant_q  <= grant_n;
            done_q   <= done_n;
            cnt_q    <= cnt_n;
            phase_q  <= phase_n;
            rep_q    <= rep_n;
            buzzer_q <= (state_n == ON);
        end
    end

    assign bus.BUZZER = buzzer_q;
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.GRANT  = grant_q;
    assign bus.DONE   = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: vector table plus corner sequences.
// Runs with TICK_DIV=1, ON_TICKS=2, OFF_TICKS=1, N_REQ=3.
module tb_buzzer_arbiter;

    logic CK;
    logic RB;
    int   total;
    int   bad;

    buzzer_arbiter_if #(.N_REQ(3)) bus ();

    buzzer_arbiter #(
        .N_REQ    (3),
        .TICK_DIV (1),
        .ON_TICKS (2),
        .OFF_TICKS(1)
    ) dut (
        .CK (CK),
        .RB (RB),
        .bus(bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic [2:0] req;
        logic [8:0] rep;
        logic       buz;
        logic       busy;
        logic [2:0] grant;
        logic [2:0] done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] req, input logic [8:0] rep,
                       input logic buz, input logic busy,
                       input logic [2:0] grant, input logic [2:0] done);
        vec_t v;
        v.req   = req;
        v.rep   = rep;
        v.buz   = buz;
        v.busy  = busy;
        v.grant = grant;
        v.done  = done;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        @(negedge CK);
    endtask

    function automatic logic [7:0] outs();
        return {bus.BUZZER, bus.BUSY, bus.GRANT, bus.DONE};
    endfunction

    localparam logic [8:0] R1 = 9'b000_000_010;
    localparam logic [8:0] R2 = 9'b001_001_001;
    localparam logic [8:0] R4 = 9'b001_001_000;

    initial begin
        total   = 0;
        bad     = 0;
        RB      = 1'b0;
        bus.REQ = 3'b000;
        bus.REP = R1;

        // single request, two bursts
        add(3'b001, R1, 0, 0, 3'b000, 3'b000);
        add(3'b000, R1, 1, 1, 3'b001, 3'b000);
        add(3'b000, R1, 1, 1, 3'b001, 3'b000);
        add(3'b000, R1, 0, 1, 3'b001, 3'b000);
        add(3'b000, R1, 1, 1, 3'b001, 3'b000);
        add(3'b000, R1, 1, 1, 3'b001, 3'b000);
        add(3'b000, R1, 0, 1, 3'b001, 3'b000);
        add(3'b000, R1, 0, 0, 3'b000, 3'b001);
        // simultaneous requests 1 and 2
        add(3'b110, R2, 0, 0, 3'b000, 3'b000);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 0, 3'b000, 3'b010);
        add(3'b000, R2, 1, 1, 3'b100, 3'b000);
        add(3'b000, R2, 1, 1, 3'b100, 3'b000);
        add(3'b000, R2, 0, 1, 3'b100, 3'b000);
        add(3'b000, R2, 0, 0, 3'b000, 3'b100);
        // REP=0 behaves as one burst
        add(3'b001, R4, 0, 0, 3'b000, 3'b000);
        add(3'b000, R4, 1, 1, 3'b001, 3'b000);
        add(3'b000, R4, 1, 1, 3'b001, 3'b000);
        add(3'b000, R4, 0, 1, 3'b001, 3'b000);
        add(3'b000, R4, 0, 0, 3'b000, 3'b001);
        add(3'b000, R4, 0, 0, 3'b000, 3'b000);
        // re-request mid-service: served twice
        add(3'b010, R2, 0, 0, 3'b000, 3'b000);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b010, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 0, 3'b000, 3'b010);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 0, 3'b000, 3'b010);
        add(3'b000, R2, 0, 0, 3'b000, 3'b000);
        // request on the granting edge is swallowed
        add(3'b010, R2, 0, 0, 3'b000, 3'b000);
        add(3'b010, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 1, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 1, 3'b010, 3'b000);
        add(3'b000, R2, 0, 0, 3'b000, 3'b010);
        add(3'b000, R2, 0, 0, 3'b000, 3'b000);

        cyc();
        cyc();
        chk("reset_outs", 32'(outs()), 32'h0);
        RB = 1'b1;
        cyc();
        chk("post_reset_idle", 32'(outs()), 32'h0);

        foreach (vq[k]) begin
            bus.REQ = vq[k].req;
            bus.REP = vq[k].rep;
            cyc();
            chk($sformatf("vec%0d", k), 32'(outs()),
                32'({vq[k].buz, vq[k].busy, vq[k].grant, vq[k].done}));
        end

        // no preemption: REQ[0] arrives while 2 plays three bursts
        bus.REP = 9'b011_000_001;
        bus.REQ = 3'b100;
        cyc();
        chk("np_pend", 32'(bus.BUSY), 32'h0);
        bus.REQ = 3'b000;
        cyc();
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("np_grant%0d", k), 32'(bus.GRANT), 32'h4);
            chk($sformatf("np_buz%0d", k), 32'(bus.BUZZER),
                32'((k % 3) != 2));
            bus.REQ = (k == 1) ? 3'b001 : 3'b000;
            cyc();
        end
        chk("np_done2", 32'(outs()), 32'({1'b0, 1'b0, 3'b000, 3'b100}));
        cyc();
        chk("np_grant0_a", 32'(outs()), 32'({1'b1, 1'b1, 3'b001, 3'b000}));
        cyc();
        chk("np_grant0_b", 32'(outs()), 32'({1'b1, 1'b1, 3'b001, 3'b000}));
        cyc();
        chk("np_gap0", 32'(outs()), 32'({1'b0, 1'b1, 3'b001, 3'b000}));
        cyc();
        chk("np_done0", 32'(outs()), 32'({1'b0, 1'b0, 3'b000, 3'b001}));

        // asynchronous reset while buzzing
        bus.REP = R1;
        bus.REQ = 3'b001;
        cyc();
        bus.REQ = 3'b000;
        cyc();
        chk("ar_on", 32'(bus.BUZZER), 32'h1);
        #2 RB = 1'b0;
        #1;
        chk("ar_buz", 32'(bus.BUZZER), 32'h0);
        chk("ar_busy", 32'(bus.BUSY), 32'h0);
        chk("ar_grant", 32'(bus.GRANT), 32'h0);
        cyc();
        RB = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("ar_quiet%0d", k), 32'(outs()), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
